sort_out_serializer: RTL and testbench
======================================

SORT_OUT_SERIALIZER -- requirements
Module: sort_out_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width.
REQ-002 SHALL have parameter N, fixed at 8, number of samples per frame.
REQ-003 SHALL have parameter DESCEND, default 0; 0 streams out0 first, 1 streams out7 first.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_complete  input  1  sorter done level, sticky high once set.
REQ-007 SHALL have port capture  input  1  one-cycle request to re-capture the current sorted frame.
REQ-008 SHALL have port in0..in7  input  DATA_W each  sorted frame, in0 smallest.
REQ-009 SHALL have port m_valid  output  1  stream beat valid.
REQ-010 SHALL have port m_ready  input  1  downstream accept.
REQ-011 SHALL have port m_data  output  DATA_W  beat payload.
REQ-012 SHALL have port m_idx  output  3  rank of current beat, 0..7, in stream order.
REQ-013 SHALL have port m_last  output  1  high with the 8th beat.
REQ-014 SHALL have port busy  output  1  high in state STREAM.
REQ-015 SHALL have port overrun  output  1  sticky flag for a trigger dropped while busy.
REQ-016 SHALL have port clr_ovr  input  1  clears overrun.

Function
REQ-017 SHALL define trigger = (in_complete high AND registered in_complete low) OR capture.
REQ-018 SHALL implement FSM IDLE/STREAM: IDLE->STREAM on trigger; STREAM->IDLE when beat 7 is accepted and no trigger is present in that cycle.
REQ-019 SHALL latch all eight inputs into an internal frame buffer in the trigger cycle T and clear beat counter to 0.
REQ-020 SHALL assert m_valid from cycle T+1, one cycle of latency.
REQ-021 SHALL complete a transfer when m_valid and m_ready are both high; the counter then increments by 1.
REQ-022 SHALL hold m_data, m_idx and m_last stable while m_valid is high and m_ready is low.
REQ-023 SHALL drive m_data = buffer[cnt] when DESCEND=0 and buffer[7-cnt] when DESCEND=1; m_idx = cnt; m_last = (cnt==7).
REQ-024 SHALL, when a trigger coincides with acceptance of beat 7, capture the new frame and stay in STREAM with cnt=0, giving back-to-back frames with no bubble.
REQ-025 SHALL ignore any other trigger during STREAM, leave the buffer unchanged, and set overrun.
REQ-026 SHALL clear overrun on clr_ovr; if clr_ovr and a set event occur in the same cycle, set wins.
REQ-027 SHALL drive m_valid low and m_data = 0 in IDLE.
REQ-028 SHALL let m_ready have no effect in IDLE.

Reset
REQ-029 SHALL, on rst high at a clock edge, force IDLE, cnt=0, buffer=0, m_valid=0, m_data=0, m_idx=0, m_last=0, busy=0, overrun=0, and registered in_complete=0.
REQ-030 SHALL abort an in-progress frame without further beats when reset is asserted mid-stream.
REQ-031 SHALL treat in_complete already high at reset release as a rising edge, which triggers a capture in the first cycle after reset.

Structure
REQ-032 SHALL place the FSM state encoding, N, and the beat-counter width constant in shared package sort_pkg.
REQ-033 SHALL be a single module with no sub-modules; the edge detector and buffer are inline.

Verification
REQ-034 SHALL verify: in0..in7=1..8, in_complete rises, m_ready=1 -> beats 1..8 on cycles T+1..T+8, m_last only with 8, busy falls after the last beat.
REQ-035 SHALL verify: DESCEND=1, same frame -> beats 8..1, m_idx 0..7.
REQ-036 SHALL verify: m_ready low for 3 cycles at beat 2 -> m_data=3 and m_idx=2 held for all 3 cycles, and no beat is lost.
REQ-037 SHALL verify: capture pulsed at beat 4 -> stream continues unchanged and overrun=1; clr_ovr -> overrun=0.
REQ-038 SHALL verify: capture in the same cycle beat 7 is accepted, with new frame 10..17 -> next cycle m_data=10, m_idx=0, and no idle cycle.
REQ-039 SHALL verify: rst asserted at beat 5 -> next cycle m_valid=0 and overrun=0; in_complete held high at release -> new frame streams from beat 0.

Source files
------------

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared FSM encoding and frame geometry for the sort output serializer
package sort_pkg;
  localparam int N     = 8;
  localparam int CNT_W = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;
endpackage

// File: rtl/sort_out_serializer.sv
// rtl/sort_out_serializer.sv - latches a sorted 8-sample frame and streams it out one beat per handshake
module sort_out_serializer #(
  parameter int DATA_W  = 16,
  parameter int N       = sort_pkg::N,
  parameter bit DESCEND = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_complete,
  input  logic              capture,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [DATA_W-1:0] in5,
  input  logic [DATA_W-1:0] in6,
  input  logic [DATA_W-1:0] in7,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [2:0]        m_idx,
  output logic              m_last,
  output logic              busy,
  output logic              overrun,
  input  logic              clr_ovr
);
  import sort_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               ic_q;
  logic [DATA_W-1:0]  frame_q [N];
  logic [DATA_W-1:0]  in_vec  [N];
  logic [CNT_W-1:0]   rd_idx;
  logic               trigger;
  logic               accept;
  logic               wrap;
  logic               set_ovr;

  always_comb begin
    in_vec[0] = in0;
    in_vec[1] = in1;
    in_vec[2] = in2;
    in_vec[3] = in3;
    in_vec[4] = in4;
    in_vec[5] = in5;
    in_vec[6] = in6;
    in_vec[7] = in7;
  end

  assign trigger = (in_complete && !ic_q) || capture;
  assign accept  = (state == STREAM) && m_ready;
  assign wrap    = accept && (cnt == LAST);
  // Only a trigger landing on the final accepted beat chains a new frame; anything else mid-stream is dropped.
  assign set_ovr = trigger && (state == STREAM) && !wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ic_q    <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < N; i++) frame_q[i] <= '0;
    end else begin
      ic_q <= in_complete;
      if (set_ovr)      overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (trigger) begin
            frame_q <= in_vec;
            cnt     <= '0;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (wrap) begin
            cnt <= '0;
            if (trigger) frame_q <= in_vec;
            else         state   <= IDLE;
          end else if (accept) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_idx  = DESCEND ? (LAST - cnt) : cnt;
  assign busy    = (state == STREAM);
  assign m_valid = busy;
  assign m_data  = busy ? frame_q[rd_idx] : '0;
  assign m_idx   = busy ? cnt : 3'd0;
  assign m_last  = busy && (cnt == LAST);
endmodule

// File: tb/tb_sort_out_serializer.sv
// tb/tb_sort_out_serializer.sv - directed self-checking bench for sort_out_serializer (ascending and descending)
module tb_sort_out_serializer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_complete;
  logic        capture;
  logic        m_ready;
  logic        clr_ovr;
  logic [15:0] din [8];

  logic        m_valid, m_last, busy, overrun;
  logic [15:0] m_data;
  logic [2:0]  m_idx;
  logic        d_valid, d_last, d_busy, d_overrun;
  logic [15:0] d_data;
  logic [2:0]  d_idx;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sort_out_serializer #(.DATA_W(16), .N(8), .DESCEND(1'b0)) dut (
    .clk(clk), .rst(rst), .in_complete(in_complete), .capture(capture),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx),
    .m_last(m_last), .busy(busy), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  sort_out_serializer #(.DATA_W(16), .N(8), .DESCEND(1'b1)) dut_desc (
    .clk(clk), .rst(rst), .in_complete(in_complete), .capture(capture),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
    .m_valid(d_valid), .m_ready(m_ready), .m_data(d_data), .m_idx(d_idx),
    .m_last(d_last), .busy(d_busy), .overrun(d_overrun), .clr_ovr(clr_ovr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input int base);
    for (int i = 0; i < 8; i++) din[i] = 16'(base + i);
  endtask

  task automatic check_beat(input string tag, input int k, input int asc, input int desc);
    chk({tag, ".valid"}, 32'(m_valid), 32'd1);
    chk({tag, ".data"},  32'(m_data),  32'(asc));
    chk({tag, ".idx"},   32'(m_idx),   32'(k));
    chk({tag, ".last"},  32'(m_last),  32'(k == 7));
    chk({tag, ".ddata"}, 32'(d_data),  32'(desc));
    chk({tag, ".didx"},  32'(d_idx),   32'(k));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".valid"}, 32'(m_valid), 32'd0);
    chk({tag, ".busy"},  32'(busy),    32'd0);
    chk({tag, ".data"},  32'(m_data),  32'd0);
    chk({tag, ".last"},  32'(m_last),  32'd0);
    chk({tag, ".dvalid"}, 32'(d_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_complete = 1'b0; capture = 1'b0; m_ready = 1'b1; clr_ovr = 1'b0;
    set_frame(1);
    step();
    step();
    check_idle("reset");
    chk("reset.idx", 32'(m_idx), 32'd0);
    chk("reset.ovr", 32'(overrun), 32'd0);

    // Rising in_complete, full-rate drain
    rst = 1'b0;
    step();
    check_idle("pre_trig");
    in_complete = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      check_beat("asc", k, k + 1, 8 - k);
      step();
    end
    check_idle("asc_done");
    step();
    check_idle("no_retrig");

    // Backpressure held for three cycles on beat 2
    capture = 1'b1;
    step();
    capture = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check_beat("stall_pre", k, k + 1, 8 - k);
      step();
    end
    m_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      check_beat("stall_hold", 2, 3, 6);
      step();
    end
    m_ready = 1'b1;
    for (int k = 2; k < 8; k++) begin
      check_beat("stall_post", k, k + 1, 8 - k);
      step();
    end
    check_idle("stall_done");

    // Mid-stream capture is dropped, overrun flagged, then cleared
    capture = 1'b1;
    step();
    capture = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_beat("ovr", k, k + 1, 8 - k);
      if (k == 4) begin
        set_frame(10);
        capture = 1'b1;
      end
      step();
      capture = 1'b0;
      if (k == 4) chk("ovr.set", 32'(overrun), 32'd1);
    end
    check_idle("ovr_done");
    chk("ovr.sticky", 32'(overrun), 32'd1);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("ovr.clr", 32'(overrun), 32'd0);

    // Capture coinciding with beat 7 acceptance chains the next frame
    set_frame(1);
    capture = 1'b1;
    step();
    capture = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_beat("b2b_a", k, k + 1, 8 - k);
      if (k == 7) begin
        set_frame(10);
        capture = 1'b1;
      end
      step();
      capture = 1'b0;
    end
    chk("b2b.busy", 32'(busy), 32'd1);
    chk("b2b.ovr", 32'(overrun), 32'd0);
    for (int k = 0; k < 8; k++) begin
      check_beat("b2b_b", k, 10 + k, 17 - k);
      step();
    end
    check_idle("b2b_done");

    // Reset mid-stream aborts; in_complete high at release retriggers
    set_frame(1);
    capture = 1'b1;
    step();
    capture = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_beat("rst_pre", k, k + 1, 8 - k);
      if (k == 3) capture = 1'b1;
      step();
      capture = 1'b0;
    end
    chk("rst_pre.ovr", 32'(overrun), 32'd1);
    check_beat("rst_at5", 5, 6, 3);
    rst = 1'b1;
    step();
    check_idle("rst_abort");
    chk("rst_abort.ovr", 32'(overrun), 32'd0);
    chk("rst_abort.idx", 32'(m_idx), 32'd0);
    set_frame(20);
    rst = 1'b0;
    step();
    for (int k = 0; k < 8; k++) begin
      check_beat("rst_post", k, 20 + k, 27 - k);
      step();
    end
    check_idle("rst_post_done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
